// File: rtl/traffic_monitor.sv
// Passive protocol monitor for the RED->GREEN->YELLOW light bus. It checks phase order, dwell time and code 11.
// Define TRAFFIC_MON_STATS_EN to build the cycles_done / err_count statistics counters.
module traffic_monitor #(
    parameter int unsigned RED_CYCLES    = 10,
    parameter int unsigned GREEN_CYCLES  = 10,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned TOL           = 0,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  light,
    output logic        locked,
    output logic [1:0]  cur_phase,
    output logic        err_seq,
    output logic        err_dwell,
    output logic        err_code,
    output logic        err_sticky,
    output logic [15:0] cycles_done,
    output logic [15:0] err_count
);

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] GREEN   = 2'b01;
    localparam logic [1:0] YELLOW  = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   dwell, dwell_next, dwell_inc;
    logic [CNT_W-1:0]   dwell_min, dwell_max;
    logic [1:0]         successor;
    logic               overrun, overrun_next;
    logic               change;
    logic               seq_next, dwell_err_next, code_next, cycle_next, any_err;

    always_comb begin
        dwell_min = '0;
        dwell_max = '0;
        successor = RED;
        case (cur_phase)
            RED: begin
                dwell_min = CNT_W'(RED_CYCLES - TOL);
                dwell_max = CNT_W'(RED_CYCLES + TOL + 1);
                successor = GREEN;
            end
            GREEN: begin
                dwell_min = CNT_W'(GREEN_CYCLES - TOL);
                dwell_max = CNT_W'(GREEN_CYCLES + TOL + 1);
                successor = YELLOW;
            end
            YELLOW: begin
                dwell_min = CNT_W'(YELLOW_CYCLES - TOL);
                dwell_max = CNT_W'(YELLOW_CYCLES + TOL + 1);
                successor = RED;
            end
            default: begin
                dwell_min = '0;
                dwell_max = '0;
                successor = RED;
            end
        endcase
    end

    always_comb begin
        state_next     = state;
        overrun_next   = overrun;
        seq_next       = 1'b0;
        dwell_err_next = 1'b0;
        code_next      = 1'b0;
        cycle_next     = 1'b0;

        change     = (light != cur_phase);
        dwell_inc  = (dwell == '1) ? dwell : dwell + 1'b1;
        dwell_next = change ? CNT_W'(1) : dwell_inc;
        if (change) begin
            overrun_next = 1'b0;
        end

        if (light == INVALID) begin
            code_next  = 1'b1;
            state_next = UNLOCKED;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (change) begin
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (change) begin
                        seq_next       = (light != successor);
                        // an overrun already reported this phase suppresses the exit check
                        dwell_err_next = !overrun && (dwell < dwell_min);
                        cycle_next     = (cur_phase == YELLOW) && (light == RED);
                    end else if (!overrun && (dwell_inc == dwell_max)) begin
                        dwell_err_next = 1'b1;
                        overrun_next   = 1'b1;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end

        any_err = seq_next | dwell_err_next | code_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            cur_phase  <= RED;
            dwell      <= '0;
            overrun    <= 1'b0;
            err_seq    <= 1'b0;
            err_dwell  <= 1'b0;
            err_code   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_next;
            cur_phase  <= light;
            dwell      <= dwell_next;
            overrun    <= overrun_next;
            err_seq    <= seq_next;
            err_dwell  <= dwell_err_next;
            err_code   <= code_next;
            err_sticky <= err_sticky | any_err;
        end
    end

    assign locked = (state == LOCKED);

`ifdef TRAFFIC_MON_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_done <= '0;
            err_count   <= '0;
        end else begin
            if (cycle_next && (cycles_done != '1)) begin
                cycles_done <= cycles_done + 16'd1;
            end
            if (any_err && (err_count != '1)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    assign cycles_done = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor: a rule-level reference model is checked every cycle, with literal checks per scenario.
module tb_traffic_monitor;

    localparam int TOL = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  light;
    logic        locked;
    logic [1:0]  cur_phase;
    logic        err_seq, err_dwell, err_code, err_sticky;
    logic [15:0] cycles_done, err_count;

    always #5 clk = ~clk;

    traffic_monitor #(
        .RED_CYCLES(10), .GREEN_CYCLES(10), .YELLOW_CYCLES(3), .TOL(TOL), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .light(light), .locked(locked), .cur_phase(cur_phase),
        .err_seq(err_seq), .err_dwell(err_dwell), .err_code(err_code), .err_sticky(err_sticky),
        .cycles_done(cycles_done), .err_count(err_count)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic logic [31:0] stat(input logic [31:0] x);
`ifdef TRAFFIC_MON_STATS_EN
        return x;
`else
        return 0;
`endif
    endfunction

    // Reference model: phase order is 0->1->2->0, dwell compared against a per-phase table.
    typedef struct packed {
        logic [1:0]  phase;
        logic        locked;
        logic [15:0] run_len;
        logic        flagged;
        logic        seq, dw, code, sticky;
        logic [15:0] cycles, errs;
    } mstate_t;

    mstate_t ms = '0;

    function automatic int dwell_of(input logic [1:0] p);
        int table_d [3] = '{10, 10, 3};
        return (p < 2'd3) ? table_d[p] : 0;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [1:0] v);
        mstate_t n = s;
        int      want = dwell_of(s.phase);
        bit      changed = (v != s.phase);
        n.seq  = 1'b0;
        n.dw   = 1'b0;
        n.code = (v == 2'd3);
        if (v == 2'd3) begin
            n.locked = 1'b0;
        end else if (!s.locked) begin
            n.locked = changed;
        end else if (changed) begin
            n.seq = (int'(v) != (int'(s.phase) + 1) % 3);
            n.dw  = !s.flagged && (int'(s.run_len) < want - TOL);
            if (s.phase == 2'd2 && v == 2'd0 && s.cycles != 16'hFFFF) n.cycles = s.cycles + 16'd1;
        end else if (!s.flagged && int'(s.run_len) + 1 == want + TOL + 1) begin
            n.dw      = 1'b1;
            n.flagged = 1'b1;
        end
        if (changed) begin
            n.run_len = 16'd1;
            n.flagged = 1'b0;
        end else if (s.run_len != 16'hFFFF) begin
            n.run_len = s.run_len + 16'd1;
        end
        n.phase = v;
        if (n.seq || n.dw || n.code) begin
            n.sticky = 1'b1;
            if (s.errs != 16'hFFFF) n.errs = s.errs + 16'd1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) ms <= '0;
        else       ms <= model_next(ms, light);
    end

    always @(negedge clk) begin
        chk("locked",      locked,      ms.locked);
        chk("cur_phase",   cur_phase,   ms.phase);
        chk("err_seq",     err_seq,     ms.seq);
        chk("err_dwell",   err_dwell,   ms.dw);
        chk("err_code",    err_code,    ms.code);
        chk("err_sticky",  err_sticky,  ms.sticky);
        chk("cycles_done", cycles_done, stat(ms.cycles));
        chk("err_count",   err_count,   stat(ms.errs));
    end

    int n_seq = 0, n_dw = 0, n_code = 0;
    always @(negedge clk) begin
        if (err_seq)   n_seq  <= n_seq + 1;
        if (err_dwell) n_dw   <= n_dw + 1;
        if (err_code)  n_code <= n_code + 1;
    end

    int b_seq, b_dw, b_code;

    task automatic step(input logic [1:0] v);
        light = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        light = 2'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        b_seq  = n_seq;
        b_dw   = n_dw;
        b_code = n_code;
    endtask

    initial begin
        reset = 1'b1;
        light = 2'd0;
        do_reset();
        settle();
        chk("reset_locked", locked, 0);
        chk("reset_phase", cur_phase, 0);
        chk("reset_sticky", err_sticky, 0);
        chk("reset_cycles", cycles_done, 0);
        chk("reset_errs", err_count, 0);

        // clean run
        do_reset();
        run(2'd0, 5);
        step(2'd1);
        settle();
        chk("clean_lock_first_green", locked, 1);
        run(2'd1, 9);
        run(2'd2, 3);
        run(2'd0, 10);
        run(2'd1, 10);
        run(2'd2, 3);
        step(2'd0);
        settle();
        chk("clean_cycles", cycles_done, stat(2));
        chk("clean_sticky", err_sticky, 0);
        chk("clean_pulses", (n_seq - b_seq) + (n_dw - b_dw) + (n_code - b_code), 0);

        // skipped phase
        do_reset();
        run(2'd0, 2);
        run(2'd1, 10);
        step(2'd0);
        settle();
        chk("skip_seq_pulses", n_seq - b_seq, 1);
        chk("skip_dwell_pulses", n_dw - b_dw, 0);
        chk("skip_errs", err_count, stat(1));

        // short phase
        do_reset();
        run(2'd0, 2);
        run(2'd1, 7);
        step(2'd2);
        settle();
        chk("short_dwell_pulses", n_dw - b_dw, 1);
        chk("short_seq_pulses", n_seq - b_seq, 0);

        // seq and dwell together count once
        do_reset();
        run(2'd0, 2);
        run(2'd1, 5);
        step(2'd0);
        settle();
        chk("both_seq", n_seq - b_seq, 1);
        chk("both_dwell", n_dw - b_dw, 1);
        chk("both_errs", err_count, stat(1));

        // stuck light
        do_reset();
        run(2'd0, 2);
        run(2'd1, 10);
        run(2'd2, 3);
        run(2'd0, 10);
        settle();
        chk("stuck_no_early", n_dw - b_dw, 0);
        step(2'd0);
        chk("stuck_11th", err_dwell, 1);
        run(2'd0, 14);
        step(2'd1);
        settle();
        chk("stuck_single", n_dw - b_dw, 1);
        chk("stuck_errs", err_count, stat(1));

        // illegal code
        do_reset();
        run(2'd0, 2);
        run(2'd1, 10);
        run(2'd2, 3);
        step(2'd3);
        settle();
        chk("code_unlocked", locked, 0);
        step(2'd3);
        step(2'd1);
        settle();
        chk("code_relocked", locked, 1);
        chk("code_pulses", n_code - b_code, 2);
        chk("code_no_seq", n_seq - b_seq, 0);
        chk("code_errs", err_count, stat(2));

        // asynchronous reset mid-GREEN
        do_reset();
        run(2'd0, 2);
        run(2'd1, 4);
        chk("pre_reset_locked", locked, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_phase", cur_phase, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        light = 2'd0;
        settle();
        chk("after_reset_locked", locked, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
